// File: rtl/encoder_pkg.sv
// Shared types for the one-hot encoder: skid-buffer FSM states and the
// encoded payload layout used by the default 8-line configuration.
package encoder_pkg;

  localparam int unsigned ENC_N_DEF = 8;
  localparam int unsigned ENC_W_DEF = $clog2(ENC_N_DEF);

  typedef enum logic [1:0] {
    ENC_EMPTY = 2'd0,
    ENC_HALF  = 2'd1,
    ENC_FULL  = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [ENC_W_DEF-1:0] code;
    logic                 zero;
    logic                 multi;
  } enc_payload_t;

  // True when a word is malformed and must be counted.
  function automatic logic enc_is_error(input logic zero, input logic multi);
    return zero | multi;
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder with all-zero and multi-hot detection.
module lsb_priority_enc #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_data,
  output logic [W-1:0] o_code,
  output logic         o_zero,
  output logic         o_multi
);

  logic [N-1:0] w_clear_lsb;

  // Walking down from the MSB lets the lowest set bit win.
  always_comb begin
    o_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_data[i]) o_code = W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only for multi-hot words.
  assign w_clear_lsb = i_data & (i_data - N'(1));
  assign o_zero      = (i_data == '0);
  assign o_multi     = (w_clear_lsb != '0);

endmodule

// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder behind a two-entry skid buffer,
// with a saturating count of malformed words.
module onehot_encoder
  import encoder_pkg::*;
#(
  parameter  int unsigned N     = 8,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;

  logic [W-1:0]     r_main_code;
  logic             r_main_zero;
  logic             r_main_multi;
  logic [W-1:0]     r_skid_code;
  logic             r_skid_zero;
  logic             r_skid_multi;
  logic [CNT_W-1:0] r_err_count;

  logic [W-1:0]     w_enc_code;
  logic             w_enc_zero;
  logic             w_enc_multi;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_move_skid;

  lsb_priority_enc #(
    .N (N)
  ) u_enc (
    .i_data  (in_data),
    .o_code  (w_enc_code),
    .o_zero  (w_enc_zero),
    .o_multi (w_enc_multi)
  );

  assign in_ready   = (r_state != ENC_FULL) && !rst;
  assign out_valid  = (r_state != ENC_EMPTY);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ENC_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next state and which payload register captures what this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_move_skid = 1'b0;
    unique case (r_state)
      ENC_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ENC_HALF;
          w_load_main = 1'b1;
        end
      end
      ENC_HALF: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ENC_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ENC_EMPTY;
        end
      end
      ENC_FULL: begin
        if (w_out_fire) begin
          w_state_nxt = ENC_HALF;
          w_move_skid = 1'b1;
        end
      end
      default: w_state_nxt = ENC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_code  <= '0;
      r_main_zero  <= 1'b0;
      r_main_multi <= 1'b0;
    end else if (w_load_main) begin
      r_main_code  <= w_enc_code;
      r_main_zero  <= w_enc_zero;
      r_main_multi <= w_enc_multi;
    end else if (w_move_skid) begin
      r_main_code  <= r_skid_code;
      r_main_zero  <= r_skid_zero;
      r_main_multi <= r_skid_multi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_code  <= '0;
      r_skid_zero  <= 1'b0;
      r_skid_multi <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_code  <= w_enc_code;
      r_skid_zero  <= w_enc_zero;
      r_skid_multi <= w_enc_multi;
    end
  end

  // Counted at acceptance so a stalled word is never counted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_in_fire && enc_is_error(w_enc_zero, w_enc_multi) &&
                 (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign out_code  = r_main_code;
  assign out_zero  = r_main_zero;
  assign out_multi = r_main_multi;
  assign err_count = r_err_count;

endmodule
